// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P MMIO <-> Avalon-MM types: decoded command, read tag, read response and initiator FSM states.
package ccip_avmm_pkg;

    localparam int unsigned CCIP_AVMM_MMIO_ADDR_WIDTH = 18;
    localparam int unsigned CCIP_AVMM_MMIO_DATA_WIDTH = 64;
    localparam int unsigned CCIP_AVMM_MMIO_TID_WIDTH  = 9;

    typedef struct packed {
        logic                                 is_read;
        logic                                 is_32bit;
        logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] addr;
        logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] write_data;
    } t_ccip_avmm_mmio_cmd;

    typedef struct packed {
        logic [CCIP_AVMM_MMIO_TID_WIDTH-1:0] tid;
        logic                                is_32bit;
        logic                                addr2;
    } t_ccip_avmm_mmio_rd_tag;

    typedef struct packed {
        logic [CCIP_AVMM_MMIO_TID_WIDTH-1:0]  tid;
        logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] data;
    } t_ccip_avmm_mmio_rsp;

    typedef enum logic [1:0] {
        MMIO_IDLE        = 2'd0,
        MMIO_ISSUE       = 2'd1,
        MMIO_WAIT_CREDIT = 2'd2
    } t_ccip_avmm_mmio_state;

    // 32-bit accesses select one lane by addr[2]; 64-bit accesses use all lanes.
    function automatic logic [7:0] mmio_byteenable(input logic is_32bit, input logic addr2);
        logic [7:0] be;
        be = 8'hFF;
        if (is_32bit) begin
            be = addr2 ? 8'hF0 : 8'h0F;
        end
        return be;
    endfunction

endpackage

// File: rtl/ccip_avmm_tag_fifo.sv
// Synchronous first-word-fall-through FIFO holding read tags in issue order.
module ccip_avmm_tag_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c     = (r_count == CW'(DEPTH));
    assign o_empty_c    = (r_count == '0);
    assign o_pop_data_c = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign w_do_push    = i_push && !o_full_c;
    assign w_do_pop     = i_pop && !o_empty_c;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/ccip_avmm_mmio_initiator.sv
// Issues decoded CCI-P MMIO commands as Avalon-MM reads/writes and returns tagged read responses in order.
module ccip_avmm_mmio_initiator
    import ccip_avmm_pkg::*;
#(
    parameter int unsigned MAX_RD_OUTSTANDING = 4,
    parameter int unsigned TID_WIDTH          = CCIP_AVMM_MMIO_TID_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  t_ccip_avmm_mmio_cmd   cmd,
    input  logic [TID_WIDTH-1:0]  cmd_tid,
    output logic                  cmd_ready,
    output logic [17:0]           avmm_address,
    output logic                  avmm_read,
    output logic                  avmm_write,
    output logic [63:0]           avmm_writedata,
    output logic [7:0]            avmm_byteenable,
    input  logic                  avmm_waitrequest,
    input  logic [63:0]           avmm_readdata,
    input  logic                  avmm_readdatavalid,
    output logic                  rsp_valid,
    output logic [TID_WIDTH-1:0]  rsp_tid,
    output logic [63:0]           rsp_data,
    output logic                  err_unexpected_rsp
);

    localparam int unsigned CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;
    localparam int unsigned TAG_W = $bits(t_ccip_avmm_mmio_rd_tag);

    t_ccip_avmm_mmio_state  r_state;
    t_ccip_avmm_mmio_state  w_state_nxt;
    logic                   w_accept;
    logic                   w_complete;
    logic                   w_is_read_nxt;
    logic                   r_is_read;
    logic                   r_is_32bit;
    logic                   r_addr2;
    logic [TID_WIDTH-1:0]   r_tid;
    logic                   r_cmd_ready;
    logic                   r_avmm_read;
    logic                   r_avmm_write;
    logic [17:0]            r_avmm_address;
    logic [63:0]            r_avmm_writedata;
    logic [7:0]             r_avmm_byteenable;
    logic                   r_rsp_valid;
    t_ccip_avmm_mmio_rsp    r_rsp;
    logic                   r_err_unexpected;
    t_ccip_avmm_mmio_rd_tag w_push_tag;
    t_ccip_avmm_mmio_rd_tag w_head_tag;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_outstanding;
    logic                   w_credit_full;
    logic [63:0]            w_rsp_data;
    logic                   w_unused;

    assign w_unused = ^cmd.addr[1:0];

    assign w_credit_full = (w_outstanding == CNT_W'(MAX_RD_OUTSTANDING));
    assign w_push        = w_complete && r_is_read && !w_fifo_full;
    assign w_pop         = avmm_readdatavalid && !w_fifo_empty;
    assign w_is_read_nxt = w_accept ? cmd.is_read : r_is_read;

    assign w_push_tag.tid      = CCIP_AVMM_MMIO_TID_WIDTH'(r_tid);
    assign w_push_tag.is_32bit = r_is_32bit;
    assign w_push_tag.addr2    = r_addr2;

    assign w_rsp_data = !w_head_tag.is_32bit ? avmm_readdata
                      : {32'h0, (w_head_tag.addr2 ? avmm_readdata[63:32] : avmm_readdata[31:0])};

    ccip_avmm_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_RD_OUTSTANDING)
    ) u_tag_fifo (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_push       (w_push),
        .i_push_data  (w_push_tag),
        .i_pop        (w_pop),
        .o_pop_data_c (w_head_tag),
        .o_full_c     (w_fifo_full),
        .o_empty_c    (w_fifo_empty),
        .o_count      (w_outstanding)
    );

    // Next-state decode; reads stall in WAIT_CREDIT while all tag slots are in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            MMIO_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd.is_read && w_credit_full) ? MMIO_WAIT_CREDIT : MMIO_ISSUE;
                end
            end
            MMIO_ISSUE: begin
                if (!avmm_waitrequest) begin
                    w_complete  = 1'b1;
                    w_state_nxt = MMIO_IDLE;
                end
            end
            MMIO_WAIT_CREDIT: begin
                if (!w_credit_full) begin
                    w_state_nxt = MMIO_ISSUE;
                end
            end
            default: w_state_nxt = MMIO_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MMIO_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture and Avalon request outputs, held stable until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_ready       <= 1'b1;
            r_avmm_read       <= 1'b0;
            r_avmm_write      <= 1'b0;
            r_is_read         <= 1'b0;
            r_is_32bit        <= 1'b0;
            r_addr2           <= 1'b0;
            r_tid             <= '0;
            r_avmm_address    <= '0;
            r_avmm_writedata  <= '0;
            r_avmm_byteenable <= '0;
        end else begin
            r_cmd_ready  <= (w_state_nxt == MMIO_IDLE);
            r_avmm_read  <= (w_state_nxt == MMIO_ISSUE) && w_is_read_nxt;
            r_avmm_write <= (w_state_nxt == MMIO_ISSUE) && !w_is_read_nxt;
            if (w_accept) begin
                r_is_read         <= cmd.is_read;
                r_is_32bit        <= cmd.is_32bit;
                r_addr2           <= cmd.addr[2];
                r_tid             <= cmd_tid;
                r_avmm_address    <= {cmd.addr[17:3], 3'b000};
                r_avmm_byteenable <= mmio_byteenable(cmd.is_32bit, cmd.addr[2]);
                r_avmm_writedata  <= cmd.is_32bit ? {cmd.write_data[31:0], cmd.write_data[31:0]}
                                                  : cmd.write_data;
            end
        end
    end

    // Read responses one cycle after readdatavalid; a return with no tag is flagged instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid      <= 1'b0;
            r_rsp            <= '0;
            r_err_unexpected <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp.tid  <= w_head_tag.tid;
                r_rsp.data <= w_rsp_data;
            end
            if (avmm_readdatavalid && w_fifo_empty) begin
                r_err_unexpected <= 1'b1;
            end
        end
    end

    assign cmd_ready          = r_cmd_ready;
    assign avmm_address       = r_avmm_address;
    assign avmm_read          = r_avmm_read;
    assign avmm_write         = r_avmm_write;
    assign avmm_writedata     = r_avmm_writedata;
    assign avmm_byteenable    = r_avmm_byteenable;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_tid            = TID_WIDTH'(r_rsp.tid);
    assign rsp_data           = r_rsp.data;
    assign err_unexpected_rsp = r_err_unexpected;

endmodule

// File: tb/tb_ccip_avmm_mmio_initiator.sv
// Directed bench for ccip_avmm_mmio_initiator: writes, lane-selected reads, credit stall, overlap and stray returns.
module tb_ccip_avmm_mmio_initiator;
    import ccip_avmm_pkg::*;

    logic                clk;
    logic                reset_n;
    logic                cmd_valid;
    t_ccip_avmm_mmio_cmd cmd;
    logic [8:0]          cmd_tid;
    logic                cmd_ready;
    logic [17:0]         avmm_address;
    logic                avmm_read;
    logic                avmm_write;
    logic [63:0]         avmm_writedata;
    logic [7:0]          avmm_byteenable;
    logic                avmm_waitrequest;
    logic [63:0]         avmm_readdata;
    logic                avmm_readdatavalid;
    logic                rsp_valid;
    logic [8:0]          rsp_tid;
    logic [63:0]         rsp_data;
    logic                err_unexpected_rsp;

    int n_checks = 0;
    int n_errors = 0;

    ccip_avmm_mmio_initiator #(
        .MAX_RD_OUTSTANDING (4),
        .TID_WIDTH          (9)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cmd_valid          (cmd_valid),
        .cmd                (cmd),
        .cmd_tid            (cmd_tid),
        .cmd_ready          (cmd_ready),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .rsp_valid          (rsp_valid),
        .rsp_tid            (rsp_tid),
        .rsp_data           (rsp_data),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command in IDLE for a single accepting cycle.
    task automatic send(input logic rd, input logic b32, input logic [17:0] a,
                        input logic [63:0] wd, input logic [8:0] t);
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd       = '{is_read: rd, is_32bit: b32, addr: a, write_data: wd};
        cmd_tid   = t;
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [63:0] rd_data(input int k);
        return 64'hB0B0_0000_0000_0000 | 64'(k * 32'h0101_0101);
    endfunction

    initial begin
        reset_n            = 1'b0;
        cmd_valid          = 1'b0;
        cmd                = '0;
        cmd_tid            = '0;
        avmm_waitrequest   = 1'b0;
        avmm_readdata      = '0;
        avmm_readdatavalid = 1'b0;
        repeat (3) tick();

        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_read", 64'(avmm_read), 64'd0);
        chk("rst_write", 64'(avmm_write), 64'd0);
        chk("rst_address", 64'(avmm_address), 64'd0);
        chk("rst_byteenable", 64'(avmm_byteenable), 64'd0);
        chk("rst_writedata", avmm_writedata, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_err", 64'(err_unexpected_rsp), 64'd0);
        reset_n = 1'b1;
        tick();

        // 64-bit write stalled by three waitrequest cycles
        avmm_waitrequest = 1'b1;
        send(1'b0, 1'b0, 18'h00108, 64'hDEAD_BEEF_CAFE_F00D, 9'h000);
        for (int i = 0; i < 4; i++) begin
            chk("w64_write_held", 64'(avmm_write), 64'd1);
            chk("w64_read_low", 64'(avmm_read), 64'd0);
            chk("w64_address", 64'(avmm_address), 64'h108);
            chk("w64_be", 64'(avmm_byteenable), 64'hFF);
            chk("w64_data", avmm_writedata, 64'hDEAD_BEEF_CAFE_F00D);
            chk("w64_ready_low", 64'(cmd_ready), 64'd0);
            chk("w64_no_rsp", 64'(rsp_valid), 64'd0);
            if (i == 3) avmm_waitrequest = 1'b0;
            tick();
        end
        chk("w64_write_done", 64'(avmm_write), 64'd0);
        chk("w64_ready_back", 64'(cmd_ready), 64'd1);

        // 32-bit write to upper lane, data replicated
        send(1'b0, 1'b1, 18'h0010C, 64'hFFFF_FFFF_1234_5678, 9'h000);
        chk("w32_write", 64'(avmm_write), 64'd1);
        chk("w32_address", 64'(avmm_address), 64'h108);
        chk("w32_be", 64'(avmm_byteenable), 64'hF0);
        chk("w32_data", avmm_writedata, 64'h1234_5678_1234_5678);
        tick();
        chk("w32_done", 64'(avmm_write), 64'd0);
        chk("w32_no_rsp", 64'(rsp_valid), 64'd0);

        // 32-bit read, upper lane, data returned several cycles later
        send(1'b1, 1'b1, 18'h00014, 64'h0, 9'h1A5);
        chk("r32_read", 64'(avmm_read), 64'd1);
        chk("r32_address", 64'(avmm_address), 64'h010);
        chk("r32_be", 64'(avmm_byteenable), 64'hF0);
        tick();
        chk("r32_read_done", 64'(avmm_read), 64'd0);
        repeat (3) tick();
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'hAAAA_5555_1111_2222;
        chk("r32_rsp_not_early", 64'(rsp_valid), 64'd0);
        tick();
        avmm_readdatavalid = 1'b0;
        chk("r32_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r32_rsp_tid", 64'(rsp_tid), 64'h1A5);
        chk("r32_rsp_data", rsp_data, 64'h0000_0000_AAAA_5555);
        tick();
        chk("r32_rsp_pulse", 64'(rsp_valid), 64'd0);

        // Five 64-bit reads with returns withheld: the fifth must wait for credit
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b0, 18'(32'h20 + 32'(k) * 8), 64'h0, 9'(k));
            chk("cr_read_issued", 64'(avmm_read), 64'd1);
            tick();
        end
        send(1'b1, 1'b0, 18'h00048, 64'h0, 9'd5);
        chk("cr_wait_read_low", 64'(avmm_read), 64'd0);
        chk("cr_wait_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        chk("cr_still_waiting", 64'(avmm_read), 64'd0);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = rd_data(1);
        tick();
        avmm_readdatavalid = 1'b0;
        chk("cr_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("cr_rsp1_tid", 64'(rsp_tid), 64'd1);
        chk("cr_rsp1_data", rsp_data, rd_data(1));
        chk("cr_not_yet_issued", 64'(avmm_read), 64'd0);
        tick();
        chk("cr_fifth_issued", 64'(avmm_read), 64'd1);
        chk("cr_fifth_address", 64'(avmm_address), 64'h048);
        chk("cr_fifth_be", 64'(avmm_byteenable), 64'hFF);
        tick();
        chk("cr_fifth_done", 64'(avmm_read), 64'd0);
        chk("cr_ready_back", 64'(cmd_ready), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            avmm_readdatavalid = 1'b1;
            avmm_readdata      = rd_data(k);
            tick();
            chk("cr_b2b_valid", 64'(rsp_valid), 64'd1);
            chk("cr_b2b_tid", 64'(rsp_tid), 64'(k));
            chk("cr_b2b_data", rsp_data, rd_data(k));
        end
        avmm_readdatavalid = 1'b0;
        tick();
        chk("cr_b2b_end", 64'(rsp_valid), 64'd0);
        chk("cr_no_err", 64'(err_unexpected_rsp), 64'd0);

        // Issue completion of read B in the same cycle as the return of read A
        send(1'b1, 1'b1, 18'h00000, 64'h0, 9'h00A);
        tick();
        send(1'b1, 1'b0, 18'h00100, 64'h0, 9'h00B);
        chk("ov_b_issue", 64'(avmm_read), 64'd1);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'h1234_5678_9ABC_DEF0;
        tick();
        avmm_readdatavalid = 1'b0;
        chk("ov_a_valid", 64'(rsp_valid), 64'd1);
        chk("ov_a_tid", 64'(rsp_tid), 64'h00A);
        chk("ov_a_data", rsp_data, 64'h0000_0000_9ABC_DEF0);
        tick();
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'h0F0E_0D0C_0B0A_0908;
        tick();
        avmm_readdatavalid = 1'b0;
        chk("ov_b_valid", 64'(rsp_valid), 64'd1);
        chk("ov_b_tid", 64'(rsp_tid), 64'h00B);
        chk("ov_b_data", rsp_data, 64'h0F0E_0D0C_0B0A_0908);
        chk("ov_no_err", 64'(err_unexpected_rsp), 64'd0);

        // Stray return with nothing outstanding
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'h5555_5555_5555_5555;
        tick();
        avmm_readdatavalid = 1'b0;
        chk("stray_no_rsp", 64'(rsp_valid), 64'd0);
        chk("stray_err", 64'(err_unexpected_rsp), 64'd1);
        repeat (2) tick();
        chk("stray_err_sticky", 64'(err_unexpected_rsp), 64'd1);

        // Reset while a read is stalled on waitrequest, then a late return
        avmm_waitrequest = 1'b1;
        send(1'b1, 1'b0, 18'h00200, 64'h0, 9'h077);
        chk("mr_read_active", 64'(avmm_read), 64'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mr_read_cleared", 64'(avmm_read), 64'd0);
        chk("mr_ready", 64'(cmd_ready), 64'd1);
        chk("mr_address", 64'(avmm_address), 64'd0);
        chk("mr_be", 64'(avmm_byteenable), 64'd0);
        chk("mr_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("mr_err_cleared", 64'(err_unexpected_rsp), 64'd0);
        avmm_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_idle_read", 64'(avmm_read), 64'd0);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 64'h7777_7777_7777_7777;
        tick();
        avmm_readdatavalid = 1'b0;
        chk("mr_late_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mr_late_err", 64'(err_unexpected_rsp), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
